// File: rtl/tiny16_bus_arbiter.sv
// tiny16_bus_arbiter
// Shares one external memory bus between the tiny16 core (master 0) and a
// DMA/peripheral engine (master 1). Round-robin arbitration with the grant
// locked for one whole transaction. A bus watchdog forces completion with
// all-ones read data when the slave never answers, so the core cannot hang.
module tiny16_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  m0_valid,
    input  logic                  m0_nwr,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_data_out,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_data_in,
    input  logic                  m1_valid,
    input  logic                  m1_nwr,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_data_out,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_data_in,
    output logic                  s_valid,
    output logic                  s_nwr,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [DATA_WIDTH-1:0] s_data_out,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_ready,
    output logic [1:0]            grant,
    output logic                  timeout_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // wdog counts BUSY cycles; reaching TIMEOUT marks the forced-completion cycle
    localparam logic [15:0] WDOG_FORCE = 16'(TIMEOUT);
    localparam logic [15:0] WDOG_LAST  = 16'(TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    logic [1:0]  grant_r, grant_nxt_s;
    logic        last_r, last_nxt_s;
    logic [15:0] wdog_r, wdog_nxt_s;
    logic        terr_r, terr_nxt_s;

    logic        g_valid_s;
    logic        forced_s;

    assign g_valid_s     = grant_r[1] ? m1_valid : m0_valid;
    assign forced_s      = (state_r == ST_BUSY) && (wdog_r == WDOG_FORCE);
    assign grant         = grant_r;
    assign timeout_error = terr_r;

    // State register: all arbiter state updates on the clock edge, reset synchronously
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
            grant_r <= 2'b00;
            last_r  <= 1'b1;
            wdog_r  <= 16'd0;
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            last_r  <= last_nxt_s;
            wdog_r  <= wdog_nxt_s;
            terr_r  <= terr_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/abort/watchdog in BUSY
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_r;
        wdog_nxt_s  = wdog_r;
        terr_nxt_s  = terr_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt_s = ST_BUSY;
                    wdog_nxt_s  = 16'd0;
                    if (m0_valid && m1_valid) begin
                        // tie goes to whoever was not served last
                        grant_nxt_s = last_r ? 2'b01 : 2'b10;
                    end else if (m0_valid) begin
                        grant_nxt_s = 2'b01;
                    end else begin
                        grant_nxt_s = 2'b10;
                    end
                end else begin
                    grant_nxt_s = 2'b00;
                end
            end
            ST_BUSY: begin
                if (forced_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 2'b00;
                    last_nxt_s  = grant_r[1];
                end else if (s_ready) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 2'b00;
                    last_nxt_s  = grant_r[1];
                end else if (!g_valid_s) begin
                    // owner withdrew mid-transaction: release silently
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 2'b00;
                    last_nxt_s  = grant_r[1];
                end else begin
                    wdog_nxt_s = wdog_r + 16'd1;
                    // flag raised together with the forced ready pulse
                    if (wdog_r == WDOG_LAST) begin
                        terr_nxt_s = 1'b1;
                    end else begin
                        terr_nxt_s = terr_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = 2'b00;
            end
        endcase
    end

    // Output logic: route the granted master to the slave and the slave response back
    always_comb begin
        s_valid    = 1'b0;
        s_nwr      = 1'b0;
        s_address  = {ADDR_WIDTH{1'b0}};
        s_data_out = {DATA_WIDTH{1'b0}};
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_data_in = s_data_in;
        m1_data_in = s_data_in;
        if (state_r == ST_BUSY) begin
            if (grant_r[1]) begin
                s_nwr      = m1_nwr;
                s_address  = m1_address;
                s_data_out = m1_data_out;
            end else begin
                s_nwr      = m0_nwr;
                s_address  = m0_address;
                s_data_out = m0_data_out;
            end
            if (forced_s) begin
                // watchdog completion: withdraw request, hand back all ones
                s_valid = 1'b0;
                if (grant_r[1]) begin
                    m1_ready   = 1'b1;
                    m1_data_in = {DATA_WIDTH{1'b1}};
                end else begin
                    m0_ready   = 1'b1;
                    m0_data_in = {DATA_WIDTH{1'b1}};
                end
            end else begin
                s_valid  = g_valid_s;
                m0_ready = s_ready & ~grant_r[1];
                m1_ready = s_ready & grant_r[1];
            end
        end else begin
            s_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_tiny16_bus_arbiter.sv
// Testbench for tiny16_bus_arbiter: per-cycle vector table with a
// scoreboard queue of expected outputs, plus a contention sequence.
module tb_tiny16_bus_arbiter;

    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;
    localparam logic [15:0] Z16 = 16'h0000;

    typedef struct packed {
        logic        rn;
        logic        v0;
        logic        w0;
        logic [15:0] a0;
        logic [15:0] d0;
        logic        v1;
        logic        w1;
        logic [15:0] a1;
        logic [15:0] d1;
        logic        rdy;
        logic [15:0] sdi;
    } in_t;

    typedef struct packed {
        logic        sv;
        logic        nw;
        logic [15:0] sa;
        logic [15:0] sd;
        logic        r0;
        logic [15:0] di0;
        logic        r1;
        logic [15:0] di1;
        logic [1:0]  g;
        logic        te;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        m0_valid, m0_nwr, m0_ready;
    logic [15:0] m0_address, m0_data_out, m0_data_in;
    logic        m1_valid, m1_nwr, m1_ready;
    logic [15:0] m1_address, m1_data_out, m1_data_in;
    logic        s_valid, s_nwr, s_ready;
    logic [15:0] s_address, s_data_out, s_data_in;
    logic [1:0]  grant;
    logic        timeout_error;

    vec_t  tbl[$];
    out_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    tiny16_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
        .clk(clk), .nreset(nreset),
        .m0_valid(m0_valid), .m0_nwr(m0_nwr), .m0_address(m0_address),
        .m0_data_out(m0_data_out), .m0_ready(m0_ready), .m0_data_in(m0_data_in),
        .m1_valid(m1_valid), .m1_nwr(m1_nwr), .m1_address(m1_address),
        .m1_data_out(m1_data_out), .m1_ready(m1_ready), .m1_data_in(m1_data_in),
        .s_valid(s_valid), .s_nwr(s_nwr), .s_address(s_address),
        .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ready(s_ready),
        .grant(grant), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    function automatic in_t ii(logic rn, logic v0, logic w0, logic [15:0] a0, logic [15:0] d0,
                               logic v1, logic w1, logic [15:0] a1, logic [15:0] d1,
                               logic rdy, logic [15:0] sdi);
        ii = {rn, v0, w0, a0, d0, v1, w1, a1, d1, rdy, sdi};
    endfunction

    function automatic out_t oo(logic sv, logic nw, logic [15:0] sa, logic [15:0] sd,
                                logic r0, logic [15:0] di0, logic r1, logic [15:0] di1,
                                logic [1:0] g, logic te);
        oo = {sv, nw, sa, sd, r0, di0, r1, di1, g, te};
    endfunction

    function automatic out_t quiet(logic [15:0] sdi, logic te);
        quiet = {L, L, Z16, Z16, L, sdi, L, sdi, 2'b00, te};
    endfunction

    task automatic add(input string n, input in_t i, input out_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        tbl.push_back(v);
    endtask

    task automatic check_one();
        out_t  e;
        out_t  a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {s_valid, s_nwr, s_address, s_data_out, m0_ready, m0_data_in,
             m1_ready, m1_data_in, grant, timeout_error};
        n_total++;
        if (a !== e) begin
            $display("FAIL %s: got sv=%b nwr=%b a=%h d=%h r0=%b di0=%h r1=%b di1=%h g=%b te=%b, want sv=%b nwr=%b a=%h d=%h r0=%b di0=%h r1=%b di1=%h g=%b te=%b",
                     n, a.sv, a.nw, a.sa, a.sd, a.r0, a.di0, a.r1, a.di1, a.g, a.te,
                     e.sv, e.nw, e.sa, e.sd, e.r0, e.di0, e.r1, e.di1, e.g, e.te);
        end else begin
            n_pass++;
        end
    endtask

    // drive one cycle of stimulus, record expectation, compare before the next edge
    task automatic apply(input vec_t v);
        nreset      = v.i.rn;
        m0_valid    = v.i.v0;
        m0_nwr      = v.i.w0;
        m0_address  = v.i.a0;
        m0_data_out = v.i.d0;
        m1_valid    = v.i.v1;
        m1_nwr      = v.i.w1;
        m1_address  = v.i.a1;
        m1_data_out = v.i.d1;
        s_ready     = v.i.rdy;
        s_data_in   = v.i.sdi;
        exp_q.push_back(v.o);
        name_q.push_back(v.name);
        #2;
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t  bi;
        out_t bo;
        vec_t cv;

        // reset state
        add("reset", ii(L, L,L,Z16,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        // single read by m0, slave answers 2 cycles after s_valid
        add("rd_idle",  ii(H, H,H,16'h1234,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        add("rd_busy1", ii(H, H,H,16'h1234,Z16, L,L,Z16,Z16, L,Z16),
            oo(H,H,16'h1234,Z16, L,Z16, L,Z16, 2'b01, L));
        add("rd_busy2", ii(H, H,H,16'h1234,Z16, L,L,Z16,Z16, L,Z16),
            oo(H,H,16'h1234,Z16, L,Z16, L,Z16, 2'b01, L));
        add("rd_done",  ii(H, H,H,16'h1234,Z16, L,L,Z16,Z16, H,16'hBEEF),
            oo(H,H,16'h1234,Z16, H,16'hBEEF, L,16'hBEEF, 2'b01, L));
        add("rd_after", ii(H, L,L,Z16,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        add("idle_sready", ii(H, L,L,Z16,Z16, L,L,Z16,Z16, H,16'h1111), quiet(16'h1111, L));
        // both request right after reset: m0 first, then m1
        add("rst_b",     ii(L, L,L,Z16,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        add("both_idle", ii(H, H,H,16'h0100,16'h0011, H,L,16'h0200,16'h5A5A, L,Z16), quiet(Z16, L));
        add("both_m0",   ii(H, H,H,16'h0100,16'h0011, H,L,16'h0200,16'h5A5A, H,16'h0042),
            oo(H,H,16'h0100,16'h0011, H,16'h0042, L,16'h0042, 2'b01, L));
        add("both_gap",  ii(H, L,H,16'h0100,16'h0011, H,L,16'h0200,16'h5A5A, L,Z16), quiet(Z16, L));
        add("both_m1",   ii(H, L,H,16'h0100,16'h0011, H,L,16'h0200,16'h5A5A, H,16'h0042),
            oo(H,L,16'h0200,16'h5A5A, L,16'h0042, H,16'h0042, 2'b10, L));
        add("both_end",  ii(H, L,L,Z16,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        // m1 write; m0 bus carries decoy values that must never reach s_*
        add("wr_idle", ii(H, L,H,16'hDEAD,16'hCAFE, H,L,16'h0800,16'h00A5, L,Z16), quiet(Z16, L));
        add("wr_busy", ii(H, L,H,16'hDEAD,16'hCAFE, H,L,16'h0800,16'h00A5, L,Z16),
            oo(H,L,16'h0800,16'h00A5, L,Z16, L,Z16, 2'b10, L));
        add("wr_done", ii(H, L,H,16'hDEAD,16'hCAFE, H,L,16'h0800,16'h00A5, H,Z16),
            oo(H,L,16'h0800,16'h00A5, L,Z16, H,Z16, 2'b10, L));
        add("wr_end",  ii(H, L,H,16'hDEAD,16'hCAFE, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        // m0 withdraws valid mid-transaction: released without any ready
        add("drop_idle", ii(H, H,H,16'h0300,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        add("drop_busy", ii(H, H,H,16'h0300,Z16, L,L,Z16,Z16, L,Z16),
            oo(H,H,16'h0300,Z16, L,Z16, L,Z16, 2'b01, L));
        add("drop_viol", ii(H, L,H,16'h0300,Z16, L,L,Z16,Z16, L,Z16),
            oo(L,H,16'h0300,Z16, L,Z16, L,Z16, 2'b01, L));
        add("drop_rel",  ii(H, L,H,16'h0300,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));
        // watchdog with TIMEOUT=4: forced completion in the 5th BUSY cycle
        add("wd_idle", ii(H, H,H,16'h0400,Z16, L,L,Z16,Z16, L,16'h1234), quiet(16'h1234, L));
        for (int k = 0; k < 4; k++) begin
            add("wd_busy", ii(H, H,H,16'h0400,Z16, L,L,Z16,Z16, L,16'h1234),
                oo(H,H,16'h0400,Z16, L,16'h1234, L,16'h1234, 2'b01, L));
        end
        add("wd_force", ii(H, H,H,16'h0400,Z16, L,L,Z16,Z16, L,16'h1234),
            oo(L,H,16'h0400,Z16, H,16'hFFFF, L,16'h1234, 2'b01, H));
        add("wd_m1_idle", ii(H, L,H,16'h0400,Z16, H,L,16'h0500,16'h7777, L,16'h1234), quiet(16'h1234, H));
        add("wd_m1_done", ii(H, L,H,16'h0400,Z16, H,L,16'h0500,16'h7777, H,16'h1234),
            oo(H,L,16'h0500,16'h7777, L,16'h1234, H,16'h1234, 2'b10, H));
        add("wd_sticky",  ii(H, L,L,Z16,Z16, L,L,Z16,Z16, L,16'h1234), quiet(16'h1234, H));
        // reset while BUSY aborts silently and clears the error flag
        add("rst_idle",   ii(H, L,L,Z16,Z16, H,H,16'h0600,Z16, L,Z16), quiet(Z16, H));
        add("rst_busy",   ii(H, L,L,Z16,Z16, H,H,16'h0600,Z16, L,Z16),
            oo(H,H,16'h0600,Z16, L,Z16, L,Z16, 2'b10, H));
        add("rst_assert", ii(L, L,L,Z16,Z16, H,H,16'h0600,Z16, L,Z16),
            oo(H,H,16'h0600,Z16, L,Z16, L,Z16, 2'b10, H));
        add("rst_after",  ii(H, L,L,Z16,Z16, L,L,Z16,Z16, L,Z16), quiet(Z16, L));

        nreset = 1'b0; m0_valid = 1'b0; m0_nwr = 1'b0; m0_address = Z16; m0_data_out = Z16;
        m1_valid = 1'b0; m1_nwr = 1'b0; m1_address = Z16; m1_data_out = Z16;
        s_ready = 1'b0; s_data_in = Z16;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
        end

        // continuous contention: both hold valid, slave always ready;
        // owners must alternate 0,1,0,1,0,1 with one IDLE cycle each
        bi = ii(H, H,H,16'h0A00,16'h00AA, H,H,16'h0B00,16'h00BB, H,16'h0C0C);
        for (int t = 0; t < 6; t++) begin
            cv.name = "cont_idle";
            cv.i    = bi;
            cv.o    = quiet(16'h0C0C, L);
            apply(cv);
            if ((t % 2) == 0) begin
                bo = oo(H,H,16'h0A00,16'h00AA, H,16'h0C0C, L,16'h0C0C, 2'b01, L);
            end else begin
                bo = oo(H,H,16'h0B00,16'h00BB, L,16'h0C0C, H,16'h0C0C, 2'b10, L);
            end
            cv.name = "cont_busy";
            cv.o    = bo;
            apply(cv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
